// File: rtl/status_indicator_pkg.sv
// Shared FSM encoding and counter widths for the LED status indicator.
// Imported by the top and the tick generator.
package status_indicator_pkg;

    localparam int PRESC_W = 32;
    localparam int PHASE_W = 16;
    localparam int BLINK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OK_HOLD  = 2'd1,
        ST_FAIL_ON  = 2'd2,
        ST_FAIL_OFF = 2'd3
    } state_e;

endpackage

// File: rtl/status_indicator_if.sv
// Event inputs and LED outputs of the status indicator.
// The master side drives the events and the slave side (the indicator) drives the LEDs.
interface status_indicator_if;
    logic evt_ok;
    logic evt_fail;
    logic led_ok;
    logic led_fail;
    logic busy;

    modport master (output evt_ok, output evt_fail,
                    input  led_ok, input  led_fail, input busy);
    modport slave  (input  evt_ok, input  evt_fail,
                    output led_ok, output led_fail, output busy);
endinterface

// File: rtl/status_indicator_tick_gen.sv
// Prescaler: tick is high for one cycle every TICK_DIV cycles, restarting from zero on clear.
// The output is combinational from the count register; there is no backpressure.
module tick_gen
    import status_indicator_pkg::*;
#(
    parameter logic [PRESC_W-1:0] TICK_DIV = 32'd1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [PRESC_W-1:0] count_q;

    assign tick = (count_q == TICK_DIV - 32'd1);

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 32'd1;
        end
    end

endmodule

// File: rtl/status_indicator.sv
// LED timing for OK and FAIL events; outputs are registered, so an event at edge N is visible from cycle N+1.
// There is no backpressure: events arriving while busy are dropped, or restart the sequence if STATUS_INDICATOR_RETRIGGER_EN is defined.
module status_indicator
    import status_indicator_pkg::*;
#(
    parameter logic [PRESC_W-1:0] TICK_DIV    = 32'd1000000,
    parameter logic [PHASE_W-1:0] OK_TICKS    = 16'd100,
    parameter logic [PHASE_W-1:0] PHASE_TICKS = 16'd25,
    parameter logic [BLINK_W-1:0] BLINK_COUNT = 8'd3
) (
    input  logic              clk,
    input  logic              reset,
    status_indicator_if.slave bus
);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               led_ok_q, led_fail_q, busy_q;
    logic               clr, tick, accept_evt;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (clr),
        .tick  (tick)
    );

`ifdef STATUS_INDICATOR_RETRIGGER_EN
    assign accept_evt = 1'b1;
`else
    assign accept_evt = (state_q == ST_IDLE);
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        blink_d = blink_q;
        clr     = 1'b0;
        case (state_q)
            ST_OK_HOLD: if (tick) begin
                if (phase_q == OK_TICKS - 16'd1) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    clr     = 1'b1;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            ST_FAIL_ON: if (tick) begin
                if (phase_q == PHASE_TICKS - 16'd1) begin
                    state_d = ST_FAIL_OFF;
                    phase_d = '0;
                    clr     = 1'b1;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            ST_FAIL_OFF: if (tick) begin
                if (phase_q == PHASE_TICKS - 16'd1) begin
                    phase_d = '0;
                    clr     = 1'b1;
                    if (blink_q == BLINK_COUNT - 8'd1) begin
                        state_d = ST_IDLE;
                        blink_d = '0;
                    end else begin
                        state_d = ST_FAIL_ON;
                        blink_d = blink_q + 8'd1;
                    end
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            default: ;
        endcase

        // A new sequence overrides any timed transition; fail has priority over ok.
        if (accept_evt && (bus.evt_fail || bus.evt_ok)) begin
            state_d = bus.evt_fail ? ST_FAIL_ON : ST_OK_HOLD;
            phase_d = '0;
            blink_d = '0;
            clr     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            blink_q    <= '0;
            led_ok_q   <= 1'b0;
            led_fail_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            blink_q    <= blink_d;
            led_ok_q   <= (state_d == ST_OK_HOLD);
            led_fail_q <= (state_d == ST_FAIL_ON);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign bus.led_ok   = led_ok_q;
    assign bus.led_fail = led_fail_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_status_indicator.sv
// Directed per-cycle check of the LED patterns with TICK_DIV=4, OK_TICKS=3, PHASE_TICKS=2, BLINK_COUNT=3.
module tb_status_indicator;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    status_indicator_if sif ();

    status_indicator #(
        .TICK_DIV    (32'd4),
        .OK_TICKS    (16'd3),
        .PHASE_TICKS (16'd2),
        .BLINK_COUNT (8'd3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic inr(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Stimulus for scenario id in cycle c: {reset, evt_fail, evt_ok}.
    function automatic logic [2:0] stim(input int id, input int c);
        logic [2:0] s;
        s = 3'b000;
        case (id)
            0: s[0] = (c == 10);
            1: s[1] = (c == 10);
            2: s[1:0] = (c == 10) ? 2'b11 : 2'b00;
            3: begin s[1] = (c == 10); s[0] = (c == 20); end
            4: begin s[1] = (c == 10) || (c == 20); s[2] = (c == 15); end
            5: s[0] = inr(c, 10, 49);
            default: s = 3'b000;
        endcase
        return s;
    endfunction

    // Hand-derived expected outputs for scenario id in cycle c: {busy, led_fail, led_ok}.
    function automatic logic [2:0] expect_out(input int id, input int c);
        logic ok, fl, bs;
        ok = 1'b0; fl = 1'b0; bs = 1'b0;
        case (id)
            0: begin ok = inr(c, 11, 22); bs = ok; end
            1, 2: begin
                fl = inr(c, 11, 18) || inr(c, 27, 34) || inr(c, 43, 50);
                bs = inr(c, 11, 58);
            end
            3: begin
`ifdef STATUS_INDICATOR_RETRIGGER_EN
                fl = inr(c, 11, 18);
                ok = inr(c, 21, 32);
                bs = inr(c, 11, 32);
`else
                fl = inr(c, 11, 18) || inr(c, 27, 34) || inr(c, 43, 50);
                bs = inr(c, 11, 58);
`endif
            end
            4: begin
                fl = inr(c, 11, 15) || inr(c, 21, 28) || inr(c, 37, 44) || inr(c, 53, 60);
                bs = inr(c, 11, 15) || inr(c, 21, 68);
            end
            5: begin
                ok = inr(c, 11, 22) || inr(c, 24, 35) || inr(c, 37, 48) || inr(c, 50, 61);
                bs = ok;
            end
            default: ;
        endcase
        return {bs, fl, ok};
    endfunction

    task automatic run_scn(input int id, input int ncyc);
        logic [2:0] s;
        logic [2:0] e;
        reset        = 1'b1;
        sif.evt_ok   = 1'b0;
        sif.evt_fail = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c <= ncyc; c++) begin
            e = expect_out(id, c);
            check($sformatf("s%0d c%0d led_ok", id, c),   {31'd0, sif.led_ok},   {31'd0, e[0]});
            check($sformatf("s%0d c%0d led_fail", id, c), {31'd0, sif.led_fail}, {31'd0, e[1]});
            check($sformatf("s%0d c%0d busy", id, c),     {31'd0, sif.busy},     {31'd0, e[2]});
            s            = stim(id, c);
            reset        = s[2];
            sif.evt_fail = s[1];
            sif.evt_ok   = s[0];
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        sif.evt_ok   = 1'b0;
        sif.evt_fail = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int id = 0; id < 6; id++) begin
            run_scn(id, 75);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
